// File: rtl/csa_pkg.sv
// Shared constants and types for the serial carry-select subtractor.
package csa_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sub_state_t;

  typedef logic [NIBBLE-1:0] nibble_t;

endpackage : csa_pkg

// File: rtl/csa_nibble.sv
// Combinational 4-bit ripple-carry adder slice.
module csa_nibble
  import csa_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);

  // Ripple the carry through each bit of the nibble.
  always_comb begin
    logic [NIBBLE:0] c;
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < NIBBLE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE];
  end

endmodule : csa_nibble

// File: rtl/csa_8_sub_serial.sv
// Serial 8-bit subtractor: diff = A - B - borrow_in, one nibble per cycle,
// with a carry-select high nibble and valid/ready on both sides.
module csa_8_sub_serial
  import csa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;        // subtrahend stored inverted
  logic             bin_q, bin_d;
  nibble_t          lo_q, lo_d;
  logic             lo_c_q, lo_c_d;
  nibble_t          hi0_q, hi0_d;
  logic             hi0_c_q, hi0_c_d;
  nibble_t          hi1_q, hi1_d;
  logic             hi1_c_q, hi1_c_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  nibble_t lo_s_c, hi0_s_c, hi1_s_c;
  logic    lo_co_c, hi0_co_c, hi1_co_c;

  // Low nibble: subtraction as addition of the inverted subtrahend, carry-in = ~borrow.
  csa_nibble u_lo (
    .a    (a_q[NIBBLE-1:0]),
    .b    (nb_q[NIBBLE-1:0]),
    .cin  (~bin_q),
    .s    (lo_s_c),
    .cout (lo_co_c)
  );

  // High nibble candidate assuming no carry from the low nibble.
  csa_nibble u_hi0 (
    .a    (a_q[WIDTH-1:NIBBLE]),
    .b    (nb_q[WIDTH-1:NIBBLE]),
    .cin  (1'b0),
    .s    (hi0_s_c),
    .cout (hi0_co_c)
  );

  // High nibble candidate assuming a carry from the low nibble.
  csa_nibble u_hi1 (
    .a    (a_q[WIDTH-1:NIBBLE]),
    .b    (nb_q[WIDTH-1:NIBBLE]),
    .cin  (1'b1),
    .s    (hi1_s_c),
    .cout (hi1_co_c)
  );

  // Next-state and datapath update for the accept / low / high / done sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    bin_d    = bin_q;
    lo_d     = lo_q;
    lo_c_d   = lo_c_q;
    hi0_d    = hi0_q;
    hi0_c_d  = hi0_c_q;
    hi1_d    = hi1_q;
    hi1_c_d  = hi1_c_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          nb_d    = ~B;
          bin_d   = borrow_in;
          state_d = LOW;
        end
      end
      LOW: begin
        lo_d    = lo_s_c;
        lo_c_d  = lo_co_c;
        hi0_d   = hi0_s_c;
        hi0_c_d = hi0_co_c;
        hi1_d   = hi1_s_c;
        hi1_c_d = hi1_co_c;
        state_d = HIGH;
      end
      HIGH: begin
        diff_d  = {(lo_c_q ? hi1_q : hi0_q), lo_q};
        bout_d  = ~(lo_c_q ? hi1_c_q : hi0_c_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are a decode of the upcoming state, so they register cleanly.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      bin_q       <= 1'b0;
      lo_q        <= '0;
      lo_c_q      <= 1'b0;
      hi0_q       <= '0;
      hi0_c_q     <= 1'b0;
      hi1_q       <= '0;
      hi1_c_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      bin_q       <= bin_d;
      lo_q        <= lo_d;
      lo_c_q      <= lo_c_d;
      hi0_q       <= hi0_d;
      hi0_c_q     <= hi0_c_d;
      hi1_q       <= hi1_d;
      hi1_c_q     <= hi1_c_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule : csa_8_sub_serial

// File: tb/tb_csa_8_sub_serial.sv
// Bench for the serial subtractor: arithmetic/timeline model plus directed vectors.
module tb_csa_8_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       borrow_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  csa_8_sub_serial dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result from plain integer subtraction, visible a fixed
  // number of edges after acceptance and held until consumed.
  int         m_phase = 0;   // 0 idle, 1..2 cycles since accept, 3 result presented
  logic [7:0] m_diff  = '0;
  logic       m_bout  = 1'b0;
  logic [7:0] m_pdiff;
  logic       m_pbout;
  bit         m_live  = 1'b0;

  always @(posedge clk) begin : model_p
    int d;
    if (rst) begin
      m_phase = 0;
      m_diff  = 8'h00;
      m_bout  = 1'b0;
      m_live  = 1'b1;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        d       = int'(A) - int'(B) - int'(borrow_in);
        m_pdiff = 8'(d);
        m_pbout = (d < 0);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_diff  = m_pdiff;
      m_bout  = m_pbout;
      m_phase = 3;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("cyc_out_valid", 32'(out_valid), 32'(m_phase == 3));
      check("cyc_diff", 32'(diff), 32'(m_diff));
      check("cyc_borrow_out", 32'(borrow_out), 32'(m_bout));
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // result appears (and, if out_ready is high, after it has been consumed).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input string nm);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    borrow_in = bi;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_ov_k"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_ov_k1"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_ov_k2"}, 32'(out_valid), 32'd1);
    check({nm, "_diff"}, 32'(diff), 32'(ed));
    check({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
    check({nm, "_model_diff"}, 32'(m_diff), 32'(ed));
    check({nm, "_model_borrow"}, 32'(m_bout), 32'(eb));
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, "_back_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    A         = 8'hAA;
    B         = 8'h55;
    borrow_in = 1'b0;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'h00);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    do_op(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "wrap0");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "wrapff");
    do_op(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, "xnib");
    do_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "equal");

    // Backpressure: result must hold while in_valid toggles operands.
    out_ready = 1'b0;
    do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A        = 8'(i * 17 + 1);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_diff", 32'(diff), 32'h1E);
      check("bp_hold_borrow", 32'(borrow_out), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_diff_held", 32'(diff), 32'h1E);

    // Reset while in HIGH: operation abandoned, no result produced.
    in_valid  = 1'b1;
    A         = 8'hC3;
    B         = 8'h18;
    borrow_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_diff", 32'(diff), 32'h00);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_pulse", 32'(out_valid), 32'd0);
    end
    do_op(8'h22, 8'h41, 1'b0, 8'hE1, 1'b1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule : tb_csa_8_sub_serial

// File: doc/csa_8_sub_serial.md
# csa_8_sub_serial

- Sequential 8-bit subtractor built from the same carry-select nibble structure as the team's 8-bit carry-select adder, operating in the opposite direction: computes A − B − borrow_in.
- Processes one 4-bit nibble per clock and uses valid/ready handshakes on both sides.
- Serves as the subtract path and as a reference operand source when checking adder results.

## Interface
- WIDTH, 8: operand width; fixed at 8, parameter exists for the package constant only.
- NIBBLE, 4: bits processed per cycle.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands.
- A  in  8  minuend.
- B  in  8  subtrahend.
- borrow_in  in  1  borrow into the LSB.
- out_valid  out  1  diff/borrow_out are valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  8  (A − B − borrow_in) mod 256.
- borrow_out  out  1  1 iff A < B + borrow_in (unsigned).

## Operation
- Arithmetic:
  - diff = A + ~B + ~borrow_in, where the low-nibble carry-in is ~borrow_in; borrow_out = ~carry_out of the high nibble.
  - All unsigned. Wrap-around is modulo 256.
- FSM states are IDLE, LOW, HIGH, DONE.
  - IDLE: in_ready=1. When in_valid=1, the block registers A, ~B and borrow_in, then moves to LOW.
  - LOW:
    - Computes the low nibble with carry-in = ~borrow_in and registers the 4-bit result and the low-nibble carry.
    - In the same cycle, computes and registers both high-nibble candidates, one for carry-in 0 and one for carry-in 1 (carry-select), each with its carry-out.
    - Moves to HIGH.
  - HIGH: selects the high-nibble candidate using the registered low carry, registers diff[7:4] and borrow_out, then moves to DONE.
  - DONE:
    - out_valid=1.
    - When out_ready=1, the result is consumed and the FSM returns to IDLE.
    - Otherwise it holds in DONE.
- in_ready=0 in LOW, HIGH and DONE. in_valid is ignored in those states; no overlap or queuing.
- diff and borrow_out hold their last values through IDLE until the next HIGH cycle overwrites them.

## Timing
- Reset values:
  - FSM state = IDLE.
  - in_ready=1, out_valid=0.
  - diff=8'h00, borrow_out=0.
  - All internal operand and candidate registers = 0.
- Latency:
  - Operands accepted at rising edge k.
  - State LOW during cycle k→k+1; state HIGH during k+1→k+2.
  - out_valid=1 from edge k+2 onward.
- Throughput: one operation per 4 cycles at best (accept, LOW, HIGH, DONE plus handshake), with out_ready held high.
- A handshake completes on any edge where valid and ready are both 1.
- out_valid stays high and diff/borrow_out stay stable while out_ready=0, for any number of cycles.
- The IDLE → accept path requires no combinational dependency from in_valid to in_ready; in_ready is a pure state decode.
- Reset asserted in any state, including mid-LOW or mid-HIGH:
  - The operation is abandoned and all outputs return to their reset values on that edge.
  - No result is produced for the abandoned operands.

## Structure
- Package csa_pkg holds:
  - localparams WIDTH=8 and NIBBLE=4.
  - typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sub_state_t.
  - typedef logic [NIBBLE-1:0] nibble_t.
- Sub-module csa_nibble:
  - Combinational 4-bit ripple adder with inputs a, b, cin and outputs s, cout.
  - Instantiated three times: the low nibble, the high candidate with cin=0, and the high candidate with cin=1.

## Test plan
- Reset: assert rst for 2 cycles while in_valid=1 → in_ready=1, out_valid=0, diff=8'h00, borrow_out=0; nothing is accepted during reset.
- Basic case: A=8'h03, B=8'h01, borrow_in=0 accepted at edge k → out_valid rises at edge k+2 with diff=8'h02, borrow_out=0.
- Wrap-around: A=8'h00, B=8'h01, borrow_in=0 → diff=8'hFF, borrow_out=1. Also A=8'hFF, B=8'hFF, borrow_in=1 → diff=8'hFF, borrow_out=1.
- Cross-nibble borrow: A=8'h10, B=8'h01, borrow_in=1 → diff=8'h0E, borrow_out=0, exercising the carry-select high candidate.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and A changing → diff/borrow_out stable, in_ready=0, no new accept; out_ready=1 → return to IDLE on the next edge.
- Reset mid-operation: assert rst during HIGH → all outputs return to reset values on the next edge with no out_valid pulse. The next operation, A=8'h22, B=8'h41, → diff=8'hE1, borrow_out=1.
